// File: rtl/univ_shift_register_seq.sv
// N-bit universal shift register with eight modes, serial outputs and a
// start/busy/done sequencer that repeats a shift or rotate a programmed number of times.
module univ_shift_register_seq #(
    parameter int N  = 8,
    parameter int CW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          start,
    input  logic [2:0]    mode,
    input  logic [CW-1:0] cnt,
    input  logic          MSB_in,
    input  logic          LSB_in,
    input  logic [N-1:0]  I,
    output logic [N-1:0]  Q,
    output logic          so_r,
    output logic          so_l,
    output logic          busy,
    output logic          done
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] rem, rem_nx;
    logic [2:0]    lmode, lmode_nx;
    logic [N-1:0]  q_nx;
    logic          done_nx;

    function automatic logic [N-1:0] apply_mode(
        input logic [2:0]   m,
        input logic [N-1:0] q,
        input logic         msb,
        input logic         lsb,
        input logic [N-1:0] d
    );
        case (m)
            3'b001:  return {msb, q[N-1:1]};
            3'b010:  return {q[N-2:0], lsb};
            3'b011:  return d;
            3'b100:  return {q[0], q[N-1:1]};
            3'b101:  return {q[N-2:0], q[N-1]};
            3'b110:  return {q[N-1], q[N-1:1]};
            3'b111:  return '0;
            default: return q;
        endcase
    endfunction

    // Only shift/rotate modes are worth sequencing; hold, load and clear
    // under start behave as a plain single step.
    function automatic logic is_seq_mode(input logic [2:0] m);
        return m inside {3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
    endfunction

    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        lmode_nx = lmode;
        q_nx     = Q;
        done_nx  = 1'b0;
        case (state)
            RUN: begin
                q_nx   = apply_mode(lmode, Q, MSB_in, LSB_in, I);
                rem_nx = rem - CW'(1);
                if (rem == CW'(1)) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: begin
                if (start && is_seq_mode(mode)) begin
                    if (cnt != '0) begin
                        lmode_nx = mode;
                        rem_nx   = cnt;
                        state_nx = RUN;
                    end else begin
                        done_nx = 1'b1;
                    end
                end else if (start || en) begin
                    q_nx = apply_mode(mode, Q, MSB_in, LSB_in, I);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rem   <= '0;
            lmode <= '0;
            Q     <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            rem   <= rem_nx;
            lmode <= lmode_nx;
            Q     <= q_nx;
            done  <= done_nx;
        end
    end

    assign busy = (state == RUN);
    assign so_r = Q[0];
    assign so_l = Q[N-1];

endmodule
